// File: rtl/morse_symbol_decoder.sv
// Keyed Morse line conditioner and dit/dah/gap/space classifier.
// Times mark and space lengths of the debounced line against a runtime dot unit.
module morse_symbol_decoder #(
  parameter int CNT_WIDTH   = 27,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int DAH_UNITS   = 2,
  parameter int ERR_UNITS   = 7,
  parameter int GAP_UNITS   = 2,
  parameter int SPACE_UNITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 signal,
  input  logic [CNT_WIDTH-1:0] unit_cycles,
  output logic [2:0]           ditsdahs,
  output logic                 sym_valid,
  output logic                 line_db
);

  localparam int TW  = CNT_WIDTH + 3;
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;
  localparam logic [2:0] SYM_ERR   = 3'd5;

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic [DBW-1:0]         db_cnt;
  logic                   ldb_d;
  logic                   rise, fall;
  logic [CNT_WIDTH-1:0]   dur;
  logic [CNT_WIDTH-1:0]   unit_q;
  state_t                 state;

  logic [TW-1:0] dur_x, th_dah, th_err, th_gap, th_space;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = line_db & ~ldb_d;
  assign fall   = ~line_db & ldb_d;

  // Widened so N*unit never truncates for any unit value.
  assign dur_x    = TW'(dur);
  assign th_dah   = TW'(unit_q) * TW'(DAH_UNITS);
  assign th_err   = TW'(unit_q) * TW'(ERR_UNITS);
  assign th_gap   = TW'(unit_q) * TW'(GAP_UNITS);
  assign th_space = TW'(unit_q) * TW'(SPACE_UNITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      db_cnt  <= '0;
      line_db <= 1'b0;
      ldb_d   <= 1'b0;
      dur     <= CNT_WIDTH'(1);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
      ldb_d  <= line_db;
      if (s_sync == line_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE - 1)) begin
        line_db <= s_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      // Restart on the registered edge so dur at a fall equals cycles high.
      if (rise | fall)
        dur <= CNT_WIDTH'(1);
      else if (~&dur)
        dur <= dur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      unit_q    <= CNT_WIDTH'(1);
      sym_valid <= 1'b0;
      ditsdahs  <= SYM_WAIT;
    end else begin
      sym_valid <= 1'b0;
      ditsdahs  <= SYM_WAIT;
      if (state == IDLE)
        unit_q <= (unit_cycles == '0) ? CNT_WIDTH'(1) : unit_cycles;
      case (state)
        IDLE: begin
          if (rise) state <= MARK;
        end
        MARK: begin
          if (fall) begin
            sym_valid <= 1'b1;
            state     <= SPACE;
            if (dur_x >= th_err)      ditsdahs <= SYM_ERR;
            else if (dur_x >= th_dah) ditsdahs <= SYM_DAH;
            else                      ditsdahs <= SYM_DIT;
          end
        end
        SPACE: begin
          // A new mark wins over a coincident gap/space threshold.
          if (rise) begin
            state <= MARK;
          end else if (dur_x == th_gap) begin
            sym_valid <= 1'b1;
            ditsdahs  <= SYM_GAP;
          end else if (dur_x == th_space) begin
            sym_valid <= 1'b1;
            ditsdahs  <= SYM_SPACE;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder: timing of every symbol checked against hand-derived cycles.
module tb_morse_symbol_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signal = 1'b0;
  logic [26:0] unit = 27'd10;
  logic [2:0]  ditsdahs, d8_sym;
  logic        sym_valid, line_db, d8_vld, d8_ldb;

  int tests = 0, fails = 0, viol = 0, cyc = 0;
  int lcyc[$], lsym[$], mcyc[$], msym[$];

  morse_symbol_decoder dut (
    .clk(clk), .rst_n(rst_n), .signal(signal), .unit_cycles(unit),
    .ditsdahs(ditsdahs), .sym_valid(sym_valid), .line_db(line_db)
  );

  morse_symbol_decoder #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .signal(signal), .unit_cycles(unit[7:0]),
    .ditsdahs(d8_sym), .sym_valid(d8_vld), .line_db(d8_ldb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (sym_valid) begin lcyc.push_back(cyc); lsym.push_back(int'(ditsdahs)); end
    if (!sym_valid && ditsdahs !== 3'd0) viol++;
    if (d8_vld) begin mcyc.push_back(cyc); msym.push_back(int'(d8_sym)); end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mark(input int hi, input int lo, output int f);
    signal = 1'b1; tick(hi);
    signal = 1'b0; f = cyc;
    tick(lo);
  endtask

  task automatic clear_logs();
    lcyc.delete(); lsym.delete(); mcyc.delete(); msym.delete();
  endtask

  task automatic test_reset();
    tick(3);
    tests++; if (sym_valid !== 1'b0) begin fails++; $display("FAIL reset sym_valid: got %b want 0", sym_valid); end
    tests++; if (ditsdahs !== 3'd0) begin fails++; $display("FAIL reset ditsdahs: got %0d want 0", ditsdahs); end
    tests++; if (line_db !== 1'b0) begin fails++; $display("FAIL reset line_db: got %b want 0", line_db); end
    rst_n = 1'b1; tick(2);
    clear_logs();
    signal = 1'b1; tick(15);
    tests++; if (line_db !== 1'b1) begin fails++; $display("FAIL reset premark line_db: got %b want 1", line_db); end
    rst_n = 1'b0; signal = 1'b0; tick(3);
    tests++; if (line_db !== 1'b0) begin fails++; $display("FAIL reset mid line_db: got %b want 0", line_db); end
    rst_n = 1'b1; tick(100);
    tests++; if (lsym.size() !== 0) begin fails++; $display("FAIL reset emissions: got %0d want 0", lsym.size()); end
    tests++; if (ditsdahs !== 3'd0 || sym_valid !== 1'b0) begin fails++; $display("FAIL reset post outputs: got %0d/%b want 0/0", ditsdahs, sym_valid); end
  endtask

  task automatic test_dit_dah();
    int f1, f2, gs, gc;
    int ec[5], es[5];
    clear_logs();
    signal = 1'b1; tick(5);
    tests++; if (line_db !== 1'b0) begin fails++; $display("FAIL edge_latency early: got %b want 0", line_db); end
    tick(1);
    tests++; if (line_db !== 1'b1) begin fails++; $display("FAIL edge_latency: got %b want 1", line_db); end
    tick(13);
    signal = 1'b0; f1 = cyc; tick(30);
    mark(20, 70, f2);
    ec = '{f1+7, f1+27, f2+7, f2+27, f2+57};
    es = '{1, 3, 2, 3, 4};
    tests++; if (lsym.size() !== 5) begin fails++; $display("FAIL dit_dah count: got %0d want 5", lsym.size()); end
    for (int i = 0; i < 5; i++) begin
      gs = -1; gc = -1;
      if (i < lsym.size()) begin gs = lsym[i]; gc = lcyc[i]; end
      tests++;
      if (gs !== es[i] || gc !== ec[i]) begin fails++; $display("FAIL dit_dah sym%0d: got %0d@%0d want %0d@%0d", i, gs, gc, es[i], ec[i]); end
    end
  endtask

  task automatic test_word_space();
    int f1, f2, gs, gc;
    int ec[6], es[6];
    clear_logs();
    mark(10, 200, f1);
    mark(10, 60, f2);
    ec = '{f1+7, f1+27, f1+57, f2+7, f2+27, f2+57};
    es = '{1, 3, 4, 1, 3, 4};
    tests++; if (lsym.size() !== 6) begin fails++; $display("FAIL word_space count: got %0d want 6", lsym.size()); end
    for (int i = 0; i < 6; i++) begin
      gs = -1; gc = -1;
      if (i < lsym.size()) begin gs = lsym[i]; gc = lcyc[i]; end
      tests++;
      if (gs !== es[i] || gc !== ec[i]) begin fails++; $display("FAIL word_space sym%0d: got %0d@%0d want %0d@%0d", i, gs, gc, es[i], ec[i]); end
    end
  endtask

  task automatic test_bounce();
    int f, gs, gc;
    int ec[3], es[3];
    logic hi;
    clear_logs();
    hi = 1'b0;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 13; k++) begin
        signal = (k < 3); tick(1); hi |= line_db;
      end
    end
    tests++; if (hi !== 1'b0) begin fails++; $display("FAIL bounce line_db: got %b want 0", hi); end
    tests++; if (lsym.size() !== 0) begin fails++; $display("FAIL bounce glitch count: got %0d want 0", lsym.size()); end
    signal = 1'b1; tick(12);
    signal = 1'b0; tick(2);
    signal = 1'b1; tick(16);
    signal = 1'b0; f = cyc; tick(70);
    ec = '{f+7, f+27, f+57};
    es = '{2, 3, 4};
    tests++; if (lsym.size() !== 3) begin fails++; $display("FAIL bounce count: got %0d want 3", lsym.size()); end
    for (int i = 0; i < 3; i++) begin
      gs = -1; gc = -1;
      if (i < lsym.size()) begin gs = lsym[i]; gc = lcyc[i]; end
      tests++;
      if (gs !== es[i] || gc !== ec[i]) begin fails++; $display("FAIL bounce sym%0d: got %0d@%0d want %0d@%0d", i, gs, gc, es[i], ec[i]); end
    end
  endtask

  task automatic test_err();
    int f1, f2, f3, gs, gc;
    int ec[9], es[9];
    clear_logs();
    mark(69, 70, f1);
    mark(70, 70, f2);
    mark(75, 70, f3);
    ec = '{f1+7, f1+27, f1+57, f2+7, f2+27, f2+57, f3+7, f3+27, f3+57};
    es = '{2, 3, 4, 5, 3, 4, 5, 3, 4};
    tests++; if (lsym.size() !== 9) begin fails++; $display("FAIL err count: got %0d want 9", lsym.size()); end
    for (int i = 0; i < 9; i++) begin
      gs = -1; gc = -1;
      if (i < lsym.size()) begin gs = lsym[i]; gc = lcyc[i]; end
      tests++;
      if (gs !== es[i] || gc !== ec[i]) begin fails++; $display("FAIL err sym%0d: got %0d@%0d want %0d@%0d", i, gs, gc, es[i], ec[i]); end
    end
  endtask

  task automatic test_saturation();
    int f, gs, gc;
    int ec[3], es[3];
    clear_logs();
    mark(10, 400, f);
    ec = '{f+7, f+27, f+57};
    es = '{1, 3, 4};
    tests++; if (msym.size() !== 3) begin fails++; $display("FAIL sat count: got %0d want 3", msym.size()); end
    for (int i = 0; i < 3; i++) begin
      gs = -1; gc = -1;
      if (i < msym.size()) begin gs = msym[i]; gc = mcyc[i]; end
      tests++;
      if (gs !== es[i] || gc !== ec[i]) begin fails++; $display("FAIL sat sym%0d: got %0d@%0d want %0d@%0d", i, gs, gc, es[i], ec[i]); end
    end
    tests++; if (dut8.dur !== 8'd255) begin fails++; $display("FAIL sat dur: got %0d want 255", dut8.dur); end
    clear_logs();
    mark(300, 70, f);
    gs = -1; gc = -1;
    if (msym.size() > 0) begin gs = msym[0]; gc = mcyc[0]; end
    tests++; if (gs !== 5 || gc !== f+7) begin fails++; $display("FAIL sat long mark: got %0d@%0d want 5@%0d", gs, gc, f+7); end
    tests++; if (msym.size() !== 3) begin fails++; $display("FAIL sat long count: got %0d want 3", msym.size()); end
    gs = -1;
    if (lsym.size() > 0) gs = lsym[0];
    tests++; if (gs !== 5) begin fails++; $display("FAIL sat wide long mark: got %0d want 5", gs); end
  endtask

  task automatic test_unit_change();
    int f1, f2, f3, f4, gs, gc;
    int ec[12], es[12];
    clear_logs();
    unit = 27'd10;
    signal = 1'b1; tick(10);
    unit = 27'd5; tick(5);
    signal = 1'b0; f1 = cyc; tick(70);
    mark(10, 40, f2);
    unit = 27'd0; tick(5);
    mark(4, 30, f3);
    mark(7, 30, f4);
    unit = 27'd10; tick(5);
    ec = '{f1+7, f1+27, f1+57, f2+7, f2+17, f2+32, f3+7, f3+9, f3+12, f4+7, f4+9, f4+12};
    es = '{1, 3, 4, 2, 3, 4, 2, 3, 4, 5, 3, 4};
    tests++; if (lsym.size() !== 12) begin fails++; $display("FAIL unit count: got %0d want 12", lsym.size()); end
    for (int i = 0; i < 12; i++) begin
      gs = -1; gc = -1;
      if (i < lsym.size()) begin gs = lsym[i]; gc = lcyc[i]; end
      tests++;
      if (gs !== es[i] || gc !== ec[i]) begin fails++; $display("FAIL unit sym%0d: got %0d@%0d want %0d@%0d", i, gs, gc, es[i], ec[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int f1, f2, f3, gs, gc;
    int ec[6], es[6];
    clear_logs();
    mark(10, 21, f1);
    mark(10, 20, f2);
    mark(10, 70, f3);
    ec = '{f1+7, f1+27, f2+7, f3+7, f3+27, f3+57};
    es = '{1, 3, 1, 1, 3, 4};
    tests++; if (lsym.size() !== 6) begin fails++; $display("FAIL b2b count: got %0d want 6", lsym.size()); end
    for (int i = 0; i < 6; i++) begin
      gs = -1; gc = -1;
      if (i < lsym.size()) begin gs = lsym[i]; gc = lcyc[i]; end
      tests++;
      if (gs !== es[i] || gc !== ec[i]) begin fails++; $display("FAIL b2b sym%0d: got %0d@%0d want %0d@%0d", i, gs, gc, es[i], ec[i]); end
    end
  endtask

  task automatic test_wait_default();
    tests++; if (viol !== 0) begin fails++; $display("FAIL wait_default: got %0d nonzero idle codes want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_dit_dah();
    test_word_space();
    test_bounce();
    test_err();
    test_saturation();
    test_unit_change();
    test_back_to_back();
    test_wait_default();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
